// File: rtl/if_fetch_if.sv
// Bundle between the fetch stage, the PC register, the instruction bus and decode.
// master = fetch stage, slave = everything around it.
interface if_fetch_if;
    logic [31:0] npc;
    logic        flush;
    logic        fetch_stall;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    modport master (
        input  npc, flush, inst_addr_ok, inst_data_ok, inst_rdata, id_ready,
        output fetch_stall, inst_req, inst_addr, if_valid, if_pc, if_inst, if_adel
    );

    modport slave (
        output npc, flush, inst_addr_ok, inst_data_ok, inst_rdata, id_ready,
        input  fetch_stall, inst_req, inst_addr, if_valid, if_pc, if_inst, if_adel
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding bus read, {pc,inst,adel} output FIFO, PC back-pressure.
// state     | meaning
// IDLE      | may issue a request (or push an address-error entry) if credit allows
// WAIT_DATA | request accepted, waiting for data_ok of tag_q
// DISCARD   | request was flushed, drop its data_ok when it arrives
module if_fetch #(
    parameter int BUF_DEPTH = 2
) (
    input  logic       clk,
    input  logic       resetn,
    if_fetch_if.master bus
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_DATA, DISCARD} state_t;

    state_t        state_q, state_d;
    logic [31:0]   tag_q, tag_d;
    logic [31:0]   pc_mem_q   [BUF_DEPTH];
    logic [31:0]   pc_mem_d   [BUF_DEPTH];
    logic [31:0]   inst_mem_q [BUF_DEPTH];
    logic [31:0]   inst_mem_d [BUF_DEPTH];
    logic          adel_mem_q [BUF_DEPTH];
    logic          adel_mem_d [BUF_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          busy, has_space, can_issue, inst_req, adel_push;
    logic          push, pop, if_valid;
    logic [31:0]   push_pc, push_inst;
    logic          push_adel;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            tag_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked by if_valid.
    always_ff @(posedge clk) begin
        pc_mem_q   <= pc_mem_d;
        inst_mem_q <= inst_mem_d;
        adel_mem_q <= adel_mem_d;
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        case (state_q)
            IDLE: begin
                if (inst_req && bus.inst_addr_ok) begin
                    state_d = WAIT_DATA;
                    tag_d   = bus.npc;
                end
            end
            WAIT_DATA: begin
                if (bus.inst_data_ok)  state_d = IDLE;
                else if (bus.flush)    state_d = DISCARD;
            end
            DISCARD: begin
                if (bus.inst_data_ok)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        has_space = (count_q + {{(CW-1){1'b0}}, busy}) < DEPTH_C;
        can_issue = resetn && !bus.flush && has_space && (state_q == IDLE);
        inst_req  = can_issue && (bus.npc[1:0] == 2'b00);
        adel_push = can_issue && (bus.npc[1:0] != 2'b00);
        if_valid  = resetn && (count_q != '0);
        pop       = if_valid && bus.id_ready;
        push      = 1'b0;
        push_pc   = bus.npc;
        push_inst = '0;
        push_adel = 1'b1;
        if (adel_push) begin
            push = 1'b1;
        end else if (state_q == WAIT_DATA && bus.inst_data_ok && !bus.flush) begin
            push      = 1'b1;
            push_pc   = tag_q;
            push_inst = bus.inst_rdata;
            push_adel = 1'b0;
        end
    end

    always_comb begin
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        adel_mem_d = adel_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]   = push_pc;
                inst_mem_d[wr_ptr_q] = push_inst;
                adel_mem_d[wr_ptr_q] = push_adel;
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
        end
    end

    assign bus.inst_req    = inst_req;
    assign bus.inst_addr   = bus.npc;
    assign bus.fetch_stall = !((inst_req && bus.inst_addr_ok) || adel_push);
    assign bus.if_valid    = if_valid;
    assign bus.if_pc       = if_valid ? pc_mem_q[rd_ptr_q]   : '0;
    assign bus.if_inst     = if_valid ? inst_mem_q[rd_ptr_q] : '0;
    assign bus.if_adel     = if_valid ? adel_mem_q[rd_ptr_q] : 1'b0;
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: expected FIFO entries go into a queue, a negedge monitor pops them.
module tb_if_fetch;
    logic clk;
    logic resetn;
    if_fetch_if bus_if();

    if_fetch #(.BUF_DEPTH(2)) dut (.clk(clk), .resetn(resetn), .bus(bus_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } entry_t;

    entry_t exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && bus_if.if_valid && bus_if.id_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h with no entry expected", bus_if.if_pc);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                chk("pop_pc",   bus_if.if_pc,   e.pc);
                chk("pop_inst", bus_if.if_inst, e.inst);
                chk("pop_adel", {31'b0, bus_if.if_adel}, {31'b0, e.adel});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Accept cycle at addr followed by the data cycle; leaves the entry in the FIFO.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
        bus_if.npc          = addr;
        bus_if.inst_addr_ok = 1'b1;
        bus_if.inst_data_ok = 1'b0;
        settle();
        chk("req_accept",   {31'b0, bus_if.inst_req},    32'd1);
        chk("addr_accept",  bus_if.inst_addr,            addr);
        chk("stall_accept", {31'b0, bus_if.fetch_stall}, 32'd0);
        exp_q.push_back('{pc: addr, inst: data, adel: 1'b0});
        tick();
        bus_if.inst_addr_ok = 1'b0;
        bus_if.npc          = addr + 32'd4;
        bus_if.inst_data_ok = 1'b1;
        bus_if.inst_rdata   = data;
        settle();
        chk("req_wait",   {31'b0, bus_if.inst_req},    32'd0);
        chk("stall_wait", {31'b0, bus_if.fetch_stall}, 32'd1);
        tick();
        bus_if.inst_data_ok = 1'b0;
        bus_if.inst_rdata   = 32'h0;
    endtask

    initial begin
        resetn              = 1'b0;
        bus_if.npc          = 32'hbfc00000;
        bus_if.flush        = 1'b0;
        bus_if.inst_addr_ok = 1'b1;
        bus_if.inst_data_ok = 1'b0;
        bus_if.inst_rdata   = 32'h0;
        bus_if.id_ready     = 1'b1;
        tick();
        tick();
        settle();
        chk("rst_valid", {31'b0, bus_if.if_valid},    32'd0);
        chk("rst_req",   {31'b0, bus_if.inst_req},    32'd0);
        chk("rst_stall", {31'b0, bus_if.fetch_stall}, 32'd1);
        chk("rst_pc",    bus_if.if_pc,                32'h0);
        chk("rst_inst",  bus_if.if_inst,              32'h0);
        chk("rst_adel",  {31'b0, bus_if.if_adel},     32'd0);
        tick();
        resetn = 1'b1;

        // 1: single fetch straight out of reset
        do_fetch(32'hbfc00000, 32'h24080001);
        settle();
        chk("t1_valid", {31'b0, bus_if.if_valid},    32'd1);
        chk("t1_stall", {31'b0, bus_if.fetch_stall}, 32'd1);
        tick();

        // 2: fill the FIFO with decode stalled, then drain and resume
        bus_if.id_ready = 1'b0;
        do_fetch(32'hbfc00000, 32'h3c1dbfc1);
        do_fetch(32'hbfc00004, 32'h27bd0100);
        bus_if.npc          = 32'hbfc00008;
        bus_if.inst_addr_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t2_full_req",   {31'b0, bus_if.inst_req},    32'd0);
            chk("t2_full_stall", {31'b0, bus_if.fetch_stall}, 32'd1);
            tick();
        end
        bus_if.inst_addr_ok = 1'b0;
        bus_if.id_ready     = 1'b1;
        settle();
        chk("t2_p1_req", {31'b0, bus_if.inst_req}, 32'd0);
        tick();
        settle();
        chk("t2_p2_req",  {31'b0, bus_if.inst_req}, 32'd1);
        chk("t2_p2_addr", bus_if.inst_addr,         32'hbfc00008);
        tick();
        settle();
        chk("t2_empty", {31'b0, bus_if.if_valid}, 32'd0);
        do_fetch(32'hbfc00008, 32'h00000000);
        tick();

        // 3: flush in WAIT_DATA, data arrives two cycles later and is dropped
        bus_if.npc          = 32'hbfc00004;
        bus_if.inst_addr_ok = 1'b1;
        settle();
        chk("t3_accept", {31'b0, bus_if.fetch_stall}, 32'd0);
        tick();
        bus_if.inst_addr_ok = 1'b0;
        bus_if.flush        = 1'b1;
        bus_if.npc          = 32'hbfc00380;
        settle();
        chk("t3_flush_req", {31'b0, bus_if.inst_req}, 32'd0);
        tick();
        bus_if.flush = 1'b0;
        exp_q.delete();
        settle();
        chk("t3_disc_req", {31'b0, bus_if.inst_req}, 32'd0);
        tick();
        bus_if.inst_data_ok = 1'b1;
        bus_if.inst_rdata   = 32'hdeadbeef;
        settle();
        chk("t3_disc_req2", {31'b0, bus_if.inst_req}, 32'd0);
        tick();
        bus_if.inst_data_ok = 1'b0;
        settle();
        chk("t3_dropped", {31'b0, bus_if.if_valid}, 32'd0);
        chk("t3_req_new", {31'b0, bus_if.inst_req}, 32'd1);
        do_fetch(32'hbfc00380, 32'h401a6800);
        tick();

        // 4: flush and data_ok in the same cycle
        bus_if.npc          = 32'hbfc00400;
        bus_if.inst_addr_ok = 1'b1;
        settle();
        chk("t4_accept", {31'b0, bus_if.fetch_stall}, 32'd0);
        tick();
        bus_if.inst_addr_ok = 1'b0;
        bus_if.flush        = 1'b1;
        bus_if.inst_data_ok = 1'b1;
        bus_if.inst_rdata   = 32'hbadc0de0;
        bus_if.npc          = 32'hbfc00500;
        tick();
        bus_if.flush        = 1'b0;
        bus_if.inst_data_ok = 1'b0;
        exp_q.delete();
        settle();
        chk("t4_empty", {31'b0, bus_if.if_valid}, 32'd0);
        chk("t4_req",   {31'b0, bus_if.inst_req}, 32'd1);
        do_fetch(32'hbfc00500, 32'h8c080000);

        // 5: misaligned npc pushes an address-error entry without a bus request
        bus_if.npc = 32'hbfc00002;
        settle();
        chk("t5_req",   {31'b0, bus_if.inst_req},    32'd0);
        chk("t5_stall", {31'b0, bus_if.fetch_stall}, 32'd0);
        exp_q.push_back('{pc: 32'hbfc00002, inst: 32'h0, adel: 1'b1});
        tick();
        bus_if.npc = 32'hbfc00010;
        settle();
        chk("t5_stall_after", {31'b0, bus_if.fetch_stall}, 32'd1);
        tick();
        tick();

        // 6: reset while a request is outstanding with an entry buffered
        bus_if.id_ready = 1'b0;
        do_fetch(32'hbfc00010, 32'h11111111);
        bus_if.npc          = 32'hbfc00014;
        bus_if.inst_addr_ok = 1'b1;
        settle();
        chk("t6_accept", {31'b0, bus_if.fetch_stall}, 32'd0);
        tick();
        bus_if.inst_addr_ok = 1'b0;
        resetn              = 1'b0;
        settle();
        chk("t6_rst_valid", {31'b0, bus_if.if_valid},    32'd0);
        chk("t6_rst_stall", {31'b0, bus_if.fetch_stall}, 32'd1);
        tick();
        resetn = 1'b1;
        exp_q.delete();
        bus_if.inst_data_ok = 1'b1;
        bus_if.inst_rdata   = 32'h22222222;
        settle();
        chk("t6_valid", {31'b0, bus_if.if_valid}, 32'd0);
        chk("t6_pc",    bus_if.if_pc,             32'h0);
        chk("t6_req",   {31'b0, bus_if.inst_req}, 32'd1);
        tick();
        bus_if.inst_data_ok = 1'b0;
        settle();
        chk("t6_late_ignored", {31'b0, bus_if.if_valid}, 32'd0);
        chk("t6_inst",         bus_if.if_inst,           32'h0);
        chk("t6_adel",         {31'b0, bus_if.if_adel},  32'd0);
        bus_if.id_ready = 1'b1;
        tick();
        tick();
        chk("left_over", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
